// File: rtl/xor_enc_pkg.sv
// xor_enc_pkg: shared state type, LFSR constants and next-state helper for the XOR stream encoder/decoder
package xor_enc_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'b0001_1101;
  localparam logic [LFSR_W-1:0] DEF_SEED = 8'hA5;
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {^(l & TAP_MASK), l[LFSR_W-1:1]};
  endfunction
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [LFSR_W-1:0] seed_of(input logic [LFSR_W-1:0] key);
    return (key == '0) ? LFSR_W'(1) : key;
  endfunction
endpackage

// File: rtl/xor_keystream.sv
// xor_keystream: 8-bit Fibonacci LFSR keystream, shared by encoder and decoder so both stay in lockstep
module xor_keystream
  import xor_enc_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEF_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  output logic ks_bit
);
  logic [LFSR_W-1:0] r_lfsr;
  always_ff @(posedge clk)
    r_lfsr <= rst ? seed_of(SEED) : adv ? lfsr_next(r_lfsr) : r_lfsr;
  assign ks_bit = r_lfsr[0];
endmodule

// File: rtl/xor_ser_enc.sv
// xor_ser_enc: parallel-in, LSB-first serial XOR keystream encoder with registered outputs
// Define XOR_ENC_PARITY_EN to append an even-parity bit after each frame.
module xor_ser_enc
  import xor_enc_pkg::*;
#(
  parameter int                WIDTH = 8,
  parameter logic [LFSR_W-1:0] KEY   = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic             r_out, r_out_valid, r_frame_start;
  logic             w_ks, w_accept, w_adv, w_last, w_ct;
`ifdef XOR_ENC_PARITY_EN
  logic             r_par;
`endif
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_adv    = w_accept || (r_state == SHIFT);
  assign w_last   = r_cnt == CW'(WIDTH - 1);
  // The word is held pre-shifted, so the next data bit is always at sreg[0].
  assign w_ct     = ((r_state == SHIFT) ? r_sreg[0] : in_data[0]) ^ w_ks;
  xor_keystream #(.SEED(KEY)) u_ks (
    .clk    (clk),
    .rst    (rst),
    .adv    (w_adv),
    .ks_bit (w_ks)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_out         <= 1'b0;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_sreg        <= r_sreg >> 1;
      r_cnt         <= r_cnt + 1'b1;
      r_out         <= w_ct;
      r_out_valid   <= 1'b1;
      r_frame_start <= 1'b0;
`ifdef XOR_ENC_PARITY_EN
      r_par         <= r_par ^ w_ct;
      if (w_last) r_state <= PARITY;
`else
      if (w_last) r_state <= IDLE;
`endif
    end
`ifdef XOR_ENC_PARITY_EN
    else if (r_state == PARITY) begin
      r_out         <= r_par;
      r_out_valid   <= 1'b1;
      r_frame_start <= 1'b0;
      r_state       <= IDLE;
    end
`endif
    else if (w_accept) begin
      r_sreg        <= in_data >> 1;
      r_cnt         <= CW'(1);
      r_out         <= w_ct;
      r_out_valid   <= 1'b1;
      r_frame_start <= 1'b1;
      r_state       <= SHIFT;
`ifdef XOR_ENC_PARITY_EN
      r_par         <= w_ct;
`endif
    end else begin
      r_out         <= 1'b0;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_state       <= IDLE;
    end
  end
  assign in_ready    = r_state == IDLE;
  assign out         = r_out;
  assign out_valid   = r_out_valid;
  assign frame_start = r_frame_start;
endmodule

// File: tb/tb_xor_ser_enc.sv
// tb_xor_ser_enc: randomized self-checking bench for xor_ser_enc against a keystream/frame reference model
module tb_xor_ser_enc;
  localparam int W = 8;
`ifdef XOR_ENC_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out, out_valid, frame_start;
  logic [W-1:0] in_data;
  logic         z_rst, z_valid, z_ready, z_out, z_ov, z_fs;
  logic [W-1:0] z_data, z_ct;
  logic [W-1:0] ct, nxt, cur;
  logic [7:0]   m_lfsr;
  int           n_chk = 0;
  int           n_err = 0;
  always #5 clk = ~clk;
  xor_ser_enc #(.WIDTH(W), .KEY(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .frame_start(frame_start)
  );
  xor_ser_enc #(.WIDTH(W), .KEY(8'h00)) dut0 (
    .clk(clk), .rst(z_rst), .in_data(z_data), .in_valid(z_valid), .in_ready(z_ready),
    .out(z_out), .out_valid(z_ov), .frame_start(z_fs)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] ks_next(input logic [7:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[4], l[7:1]};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_data = W'($urandom);
      step();
      chk("idle_valid", 32'(out_valid), 0);
      chk("idle_out", 32'(out), 0);
      chk("idle_fs", 32'(frame_start), 0);
      chk("idle_ready", 32'(in_ready), 1);
    end
  endtask
  // Sends one word; the model keystream runs on across frames and is only reseeded by reset.
  task automatic do_frame(input logic [W-1:0] w, input logic [W-1:0] nw, input bit nv,
                          input bit wig, input int abort_at, output logic [W-1:0] got);
    logic [FL-1:0] e;
    got = '0;
    for (int k = 0; k < W; k++) begin
      e[k]   = w[k] ^ m_lfsr[0];
      m_lfsr = ks_next(m_lfsr);
    end
`ifdef XOR_ENC_PARITY_EN
    e[W] = ^e[W-1:0];
`endif
    in_data  = w;
    in_valid = 1'b1;
    step();
    in_data  = nw;
    in_valid = nv;
    for (int k = 0; k < FL; k++) begin
      if (k > 0) step();
      if (k < W) got[k] = out;
      chk("bit", 32'(out), 32'(e[k]));
      chk("valid", 32'(out_valid), 1);
      chk("fs", 32'(frame_start), 32'(k == 0));
      chk("ready", 32'(in_ready), 32'(k == FL - 1));
      if (k == abort_at) begin
        rst      = 1'b1;
        in_valid = 1'b1;
        step();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_ready", 32'(in_ready), 1);
        rst      = 1'b0;
        in_valid = 1'b0;
        m_lfsr   = 8'hA5;
        return;
      end
      if (wig && k < FL - 1) begin
        in_data  = W'($urandom);
        in_valid = 1'($urandom);
      end else if (wig) begin
        in_data  = nw;
        in_valid = nv;
      end
    end
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; m_lfsr = 8'hA5;
    z_rst = 1'b1; z_valid = 1'b0; z_data = '0;
    repeat (3) step();
    chk("reset_ready", 32'(in_ready), 1);
    chk("reset_out", 32'(out), 0);
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_fs", 32'(frame_start), 0);
    rst = 1'b0; z_rst = 1'b0;
    idle(4);
    do_frame(8'h3C, '0, 1'b0, 1'b0, -1, ct);
    chk("ct_3c", 32'(ct), 32'h99);
    idle(2);
    nxt = W'($urandom);
    cur = W'($urandom);
    do_frame(cur, nxt, 1'b1, 1'b0, -1, ct);
    cur = nxt; nxt = W'($urandom);
    do_frame(cur, nxt, 1'b1, 1'b0, -1, ct);
    do_frame(nxt, '0, 1'b0, 1'b0, -1, ct);
    idle(2);
    do_frame(W'($urandom), '0, 1'b0, 1'b1, -1, ct);
    idle(1);
    do_frame(W'($urandom), '0, 1'b1, 1'b0, 4, ct);
    idle(2);
    do_frame(8'h3C, '0, 1'b0, 1'b0, -1, ct);
    chk("ct_after_rst", 32'(ct), 32'h99);
    idle(1);
    nxt = W'($urandom);
    for (int f = 0; f < 8; f++) begin
      automatic bit nv = 1'($urandom);
      cur = nxt;
      nxt = W'($urandom);
      do_frame(cur, nxt, nv, 1'($urandom), -1, ct);
      if (!nv) idle($urandom_range(1, 3));
    end
    z_data  = '0;
    z_valid = 1'b1;
    step();
    z_valid = 1'b0;
    z_ct    = '0;
    for (int k = 0; k < FL; k++) begin
      if (k > 0) step();
      if (k < W) z_ct[k] = z_out;
      chk("key0_valid", 32'(z_ov), 1);
      chk("key0_fs", 32'(z_fs), 32'(k == 0));
`ifdef XOR_ENC_PARITY_EN
      if (k == W) chk("key0_parity", 32'(z_out), 1);
`endif
    end
    chk("key0_ct", 32'(z_ct), 32'h01);
    step();
    chk("key0_idle", 32'(z_ov), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
